// File: rtl/pwm_sine_cmd_ctrl.sv
// UART command parser and double-buffered configuration for a sine PWM datapath.
// Frames are A5 CMD DATA CHK. A valid frame writes a shadow register or reads a
// live one. Shadow values move to the live outputs at a PWM period boundary,
// or straight away while the output is disabled.
//   clk, rst_n          : clock, synchronous active-low reset
//   rx_data/rx_valid    : received bytes, one-cycle strobe
//   tx_data/tx_valid    : response bytes, held until tx_ready
//   period_end          : PWM period boundary pulse
//   phase_inc/amplitude/out_en : live configuration
//   cfg_update          : pulse when the live configuration loads
module pwm_sine_cmd_ctrl #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        period_end,
  output logic [15:0] phase_inc,
  output logic [7:0]  amplitude,
  output logic        out_en,
  output logic        cfg_update
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0] SOF_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {S_HUNT, S_GET_CMD, S_GET_DATA, S_GET_CHK, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         cmd_q, cmd_d, data_q, data_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               two_q, two_d;          // a read value byte follows the ACK
  logic               rd_cap_q, rd_cap_d;    // read value already sampled
  logic [7:0]         rd_val_q, rd_val_d;
  logic [15:0]        sh_phase_q, sh_phase_d, phase_q, phase_d;
  logic [7:0]         sh_amp_q, sh_amp_d, amp_q, amp_d;
  logic               sh_en_q, sh_en_d, en_q, en_d;
  logic               pending_q, pending_d;
  logic               cfg_upd_q, cfg_upd_d;
  logic               wr_en, is_wr, is_rd, chk_ok, load;
  logic [7:0]         live_sel;

  // Command decode and live register read mux
  always_comb begin
    is_wr  = (cmd_q >= 8'h01) && (cmd_q <= 8'h04);
    is_rd  = (cmd_q >= 8'h81) && (cmd_q <= 8'h84);
    chk_ok = (rx_data == (cmd_q ^ data_q));
    case (cmd_q[1:0])
      2'b01:   live_sel = phase_q[7:0];
      2'b10:   live_sel = phase_q[15:8];
      2'b11:   live_sel = amp_q;
      default: live_sel = {7'b0, en_q};
    endcase
  end

  // Parser / responder next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    two_d      = two_q;
    rd_cap_d   = rd_cap_q;
    rd_val_d   = rd_val_q;
    wr_en      = 1'b0;
    case (state_q)
      S_HUNT: begin
        cnt_d = '0;
        if (rx_valid && (rx_data == SOF_BYTE)) state_d = S_GET_CMD;
      end
      S_GET_CMD, S_GET_DATA, S_GET_CHK: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (state_q == S_GET_CMD) begin
            cmd_d   = rx_data;
            state_d = S_GET_DATA;
          end else if (state_q == S_GET_DATA) begin
            data_d  = rx_data;
            state_d = S_GET_CHK;
          end else begin
            state_d    = S_RESP;
            tx_valid_d = 1'b1;
            rd_cap_d   = 1'b0;
            two_d      = 1'b0;
            if (chk_ok && is_wr) begin
              wr_en     = 1'b1;
              tx_data_d = ACK_BYTE;
            end else if (chk_ok && is_rd) begin
              two_d     = 1'b1;
              tx_data_d = ACK_BYTE;
            end else begin
              tx_data_d = NAK_BYTE;
            end
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = S_HUNT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        // Read value is sampled in the first response cycle
        if (!rd_cap_q) begin
          rd_cap_d = 1'b1;
          rd_val_d = live_sel;
        end
        if (tx_valid_q && tx_ready) begin
          if (two_q) begin
            two_d     = 1'b0;
            tx_data_d = rd_cap_q ? rd_val_q : live_sel;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_HUNT;
          end
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  // Shadow writes and live load; a load always takes the pre-write shadow
  always_comb begin
    sh_phase_d = sh_phase_q;
    sh_amp_d   = sh_amp_q;
    sh_en_d    = sh_en_q;
    if (wr_en) begin
      case (cmd_q[2:0])
        3'd1:    sh_phase_d[7:0]  = data_q;
        3'd2:    sh_phase_d[15:8] = data_q;
        3'd3:    sh_amp_d         = data_q;
        default: sh_en_d          = data_q[0];
      endcase
    end
    load      = pending_q && (period_end || !en_q);
    phase_d   = load ? sh_phase_q : phase_q;
    amp_d     = load ? sh_amp_q   : amp_q;
    en_d      = load ? sh_en_q    : en_q;
    pending_d = wr_en || (pending_q && !load);
    cfg_upd_d = load;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_HUNT;
      cnt_q      <= '0;
      cmd_q      <= 8'h00;
      data_q     <= 8'h00;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      two_q      <= 1'b0;
      rd_cap_q   <= 1'b0;
      rd_val_q   <= 8'h00;
      sh_phase_q <= 16'h0100;
      sh_amp_q   <= 8'hFF;
      sh_en_q    <= 1'b0;
      phase_q    <= 16'h0100;
      amp_q      <= 8'hFF;
      en_q       <= 1'b0;
      pending_q  <= 1'b0;
      cfg_upd_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      two_q      <= two_d;
      rd_cap_q   <= rd_cap_d;
      rd_val_q   <= rd_val_d;
      sh_phase_q <= sh_phase_d;
      sh_amp_q   <= sh_amp_d;
      sh_en_q    <= sh_en_d;
      phase_q    <= phase_d;
      amp_q      <= amp_d;
      en_q       <= en_d;
      pending_q  <= pending_d;
      cfg_upd_q  <= cfg_upd_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign phase_inc  = phase_q;
  assign amplitude  = amp_q;
  assign out_en     = en_q;
  assign cfg_update = cfg_upd_q;

endmodule

// File: tb/tb_pwm_sine_cmd_ctrl.sv
// Directed testbench for pwm_sine_cmd_ctrl.
module tb_pwm_sine_cmd_ctrl;

  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        period_end;
  logic [15:0] phase_inc;
  logic [7:0]  amplitude;
  logic        out_en;
  logic        cfg_update;

  int n_assert = 0;
  int n_fail   = 0;

  pwm_sine_cmd_ctrl #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .period_end (period_end),
    .phase_inc  (phase_inc),
    .amplitude  (amplitude),
    .out_en     (out_en),
    .cfg_update (cfg_update)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(d);
    send_byte(k);
  endtask

  // Wait (bounded) for a response byte, check it, then step past its handshake
  task automatic expect_tx(input string tag, input logic [7:0] exp);
    int waited = 0;
    while (!tx_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 16'(tx_valid), 16'h0001);
    check(tag, 16'(tx_data), 16'(exp));
    @(negedge clk);
  endtask

  task automatic pulse_period_end();
    @(negedge clk);
    period_end = 1'b1;
    @(negedge clk);
    period_end = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_data    = 8'h00;
    rx_valid   = 1'b0;
    tx_ready   = 1'b1;
    period_end = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_tx_valid", 16'(tx_valid), 16'h0000);
    check("rst_tx_data", 16'(tx_data), 16'h0000);
    check("rst_phase", phase_inc, 16'h0100);
    check("rst_amp", 16'(amplitude), 16'h00FF);
    check("rst_out_en", 16'(out_en), 16'h0000);
    check("rst_cfg_update", 16'(cfg_update), 16'h0000);

    // Read amplitude with transmitter stalled
    tx_ready = 1'b0;
    send_frame(8'h83, 8'h00, 8'h83);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 16'(tx_valid), 16'h0001);
      check("stall_data", 16'(tx_data), 16'h0006);
      if (i < 4) @(negedge clk);
    end
    tx_ready = 1'b1;
    expect_tx("rd83_ack", 8'h06);
    expect_tx("rd83_val", 8'hFF);
    check("rd83_done", 16'(tx_valid), 16'h0000);

    // Bad checksum and unknown command, with junk bytes ahead of the frame
    send_byte(8'h00);
    send_byte(8'h11);
    send_frame(8'h03, 8'h80, 8'h00);
    expect_tx("badchk_nak", 8'h15);
    check("badchk_single", 16'(tx_valid), 16'h0000);
    check("badchk_amp", 16'(amplitude), 16'h00FF);
    send_frame(8'h07, 8'h00, 8'h07);
    expect_tx("badcmd_nak", 8'h15);
    check("badcmd_amp", 16'(amplitude), 16'h00FF);
    check("badcmd_cfg", 16'(cfg_update), 16'h0000);

    // Write amplitude while output disabled: immediate load
    send_frame(8'h03, 8'h80, 8'h83);
    expect_tx("wramp_ack", 8'h06);
    check("wramp_amp", 16'(amplitude), 16'h0080);
    check("wramp_cfg", 16'(cfg_update), 16'h0001);
    check("wramp_single", 16'(tx_valid), 16'h0000);
    @(negedge clk);
    check("wramp_cfg_pulse", 16'(cfg_update), 16'h0000);

    // Inter-byte timeout drops the frame
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO) @(negedge clk);
    send_byte(8'h34);
    send_byte(8'h35);
    repeat (4) @(negedge clk);
    check("to_no_resp", 16'(tx_valid), 16'h0000);
    check("to_phase", phase_inc, 16'h0100);
    send_frame(8'h04, 8'h01, 8'h05);
    expect_tx("to_en_ack", 8'h06);
    pulse_period_end();
    check("to_out_en", 16'(out_en), 16'h0001);

    // Write phase low byte with output enabled: waits for period_end
    send_frame(8'h01, 8'h34, 8'h35);
    expect_tx("wrph_ack", 8'h06);
    repeat (3) @(negedge clk);
    check("wrph_hold", phase_inc, 16'h0100);
    check("wrph_hold_cfg", 16'(cfg_update), 16'h0000);
    pulse_period_end();
    check("wrph_load", phase_inc, 16'h0134);
    check("wrph_cfg", 16'(cfg_update), 16'h0001);
    @(negedge clk);
    check("wrph_cfg_pulse", 16'(cfg_update), 16'h0000);

    // Shadow write coinciding with period_end
    send_frame(8'h01, 8'h11, 8'h10);
    expect_tx("coin1_ack", 8'h06);
    check("coin1_hold", phase_inc, 16'h0134);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h22);
    @(negedge clk);
    rx_data    = 8'h23;
    rx_valid   = 1'b1;
    period_end = 1'b1;
    @(negedge clk);
    rx_valid   = 1'b0;
    period_end = 1'b0;
    check("coin_old_load", phase_inc, 16'h0111);
    check("coin_cfg", 16'(cfg_update), 16'h0001);
    expect_tx("coin2_ack", 8'h06);
    check("coin_pending_hold", phase_inc, 16'h0111);
    pulse_period_end();
    check("coin_new_load", phase_inc, 16'h0122);

    // Read back the live registers
    send_frame(8'h81, 8'h00, 8'h81);
    expect_tx("rd81_ack", 8'h06);
    expect_tx("rd81_val", 8'h22);
    send_frame(8'h82, 8'h55, 8'h82 ^ 8'h55);
    expect_tx("rd82_ack", 8'h06);
    expect_tx("rd82_val", 8'h01);
    send_frame(8'h84, 8'h00, 8'h84);
    expect_tx("rd84_ack", 8'h06);
    expect_tx("rd84_val", 8'h01);

    // Reset during a response
    tx_ready = 1'b0;
    send_frame(8'h83, 8'h00, 8'h83);
    check("rstresp_pre", 16'(tx_valid), 16'h0001);
    do_reset();
    check("rstresp_valid", 16'(tx_valid), 16'h0000);
    check("rstresp_data", 16'(tx_data), 16'h0000);
    check("rstresp_phase", phase_inc, 16'h0100);
    tx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rstresp_quiet", 16'(tx_valid), 16'h0000);

    // Reset mid-frame: the tail of the frame is ignored
    send_byte(8'hA5);
    send_byte(8'h03);
    do_reset();
    send_byte(8'h80);
    send_byte(8'h83);
    repeat (4) @(negedge clk);
    check("rstframe_quiet", 16'(tx_valid), 16'h0000);
    check("rstframe_amp", 16'(amplitude), 16'h00FF);

    // 0xA5 inside a frame is data
    send_frame(8'h03, 8'hA5, 8'hA6);
    expect_tx("a5data_ack", 8'h06);
    check("a5data_amp", 16'(amplitude), 16'h00A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
